div_sweep_ctrl: RTL and testbench
=================================

Name: div_sweep_ctrl

Overview:
- Programmable frequency-sweep sequencer for the variable clock divider.
- Holds a small table of (divide value, hold count) entries written by a host.
- On start, steps through the table and drives a divided waveform; each entry runs for a programmed number of output periods.
- Divide-value changes take effect only on a period boundary, so the output never produces runt pulses. Sits between a control register block and the audio/LED driver.

Parameters:
- DEPTH, 8, number of table entries (power of 2, 2..16)
- HOLD_W, 8, width of per-entry hold count (output periods)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  table write strobe (ignored while busy)
- wr_idx  in  $clog2(DEPTH)  table entry address
- wr_div  in  5  divide value for entry; ratio = div+1
- wr_hold  in  HOLD_W  periods to hold entry; 0 means skip entry
- num_entries  in  $clog2(DEPTH)+1  active entries, sampled at start; 0 -> immediate done
- start  in  1  begin sweep (pulse; ignored while busy)
- abort  in  1  stop sweep at once
- out  out  1  divided waveform
- cur_div  out  5  divide value currently applied
- cur_idx  out  $clog2(DEPTH)  entry currently running
- busy  out  1  high in LOAD/RUN
- done  out  1  one-cycle pulse when the sweep finishes or aborts

Behaviour:
- Reset: clock is clk; reset is synchronous, active-high. On reset, state=IDLE, out=0, cur_div=0, cur_idx=0, busy=0, done=0, period counter=0. Table contents are not reset.
- Table: registers written in the cycle wr_en=1 and busy=0. A write is visible to a start issued in the following cycle.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: start=1 -> LOAD with idx=0, latch n=num_entries. If n=0, go -> DONE.
  - LOAD (1 cycle): if hold[idx]=0, advance idx. If idx+1==n, go -> DONE; otherwise stay in LOAD. If hold[idx]!=0, apply cur_div=div[idx], clear the period counter, set remaining=hold[idx] -> RUN.
  - RUN: the core counter increments every clk and wraps at cur_div.
    - A period end is the cycle when counter==cur_div.
    - At each period end, remaining decrements. When it reaches 0, advance to the next entry via LOAD, or go -> DONE if idx+1==n.
  - DONE (1 cycle): done=1, out=0 -> IDLE.
- Waveform per period (div+1 clocks): out low for the first floor(div/2)+1 clocks and high for the remaining ceil(div/2) clocks. With div=0, out stays low and a period is 1 clock.
- out changes only on register edges; it is 0 in IDLE, LOAD and DONE.
- Entry latency: first output clock of an entry is the cycle after LOAD. Gap between consecutive entries is exactly one LOAD cycle per entry, including skipped entries.
- abort: has priority over start and over everything except reset. In LOAD/RUN it goes -> DONE next cycle. In IDLE/DONE it is ignored.
- start while busy is ignored. start and abort in the same cycle in IDLE: abort wins, so no sweep starts.
- cur_idx/cur_div hold their last values after DONE until the next LOAD.

Optional Feature:
- Macro DIV_SWEEP_LOOP_EN.
- Defined: adds an input loop (1 bit). If loop=1 when the last entry completes, go LOAD with idx=0 instead of DONE, with no done pulse; the sweep runs until abort. If every entry has hold=0, go -> DONE to avoid a livelock.
- Undefined: no loop port; the sweep always ends in DONE after the last entry.

Decomposition:
- Package div_sweep_pkg: state enum (IDLE, LOAD, RUN, DONE), DIV_W=5, and the entry struct {div, hold}.
- One sub-module, div_core: a counter plus waveform generator with a 5-bit div input and a clear input, which emits out and a period_end pulse. The FSM and table stay in div_sweep_ctrl.

Test Plan:
- Reset check: assert reset mid-RUN -> next cycle out=0, busy=0, no done pulse; table contents unchanged on re-start.
- Single entry: div=3, hold=2, n=1 -> after start, 1 LOAD cycle, then out pattern 0,0,1,1,0,0,1,1, then done pulse, busy=0.
- Odd ratio and sequencing: entries {div=4, hold=1}, {div=1, hold=3}, n=2 -> out 0,0,0,1,1, then LOAD gap 0, then 0,1,0,1,0,1, then done; cur_div shows 4 then 1.
- Skip and empty: entry0 hold=0, entry1 {div=2, hold=1}, n=2 -> two LOAD cycles, then 0,0,1. Separately, n=0 -> done two cycles after start.
- Abort mid-period: div=7, hold=5, abort at counter=5 -> out=0 next cycle, done pulse, IDLE. start together with abort in IDLE -> busy stays 0.
- Loop (macro defined): loop=1, {div=1, hold=1}, n=1 -> out repeats 0,1,gap 0 indefinitely with no done; abort -> done.

Source files
------------

// File: rtl/div_sweep_pkg.sv
// Shared types for the frequency-sweep sequencer.
//   state_t : sequencer FSM states
//   DIV_W   : width of a divide value (ratio = div + 1)
//   entry_t : one sweep table entry {div, hold}
// The hold field is sized for the widest supported hold count. Narrower
// builds zero-extend on write, so the unused upper bits are constant.
package div_sweep_pkg;
  localparam int DIV_W      = 5;
  localparam int HOLD_MAX_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic [DIV_W-1:0]      div;
    logic [HOLD_MAX_W-1:0] hold;
  } entry_t;
endpackage

// File: rtl/div_core.sv
// Period counter and waveform generator.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count at 0 on this edge
//   run        : core produces output in the coming cycle
//   div        : divide value; one period is div+1 clocks
//   out        : registered waveform, low for floor(div/2)+1 clocks, then high
//   period_end : high in the last clock of a period while running
// out is computed from the next count so that the registered value lines up
// with the count it belongs to; it is forced low whenever run is low.
module div_core
  import div_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             out,
  output logic             period_end
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_n;
  logic             active;

  always_comb begin
    cnt_n = cnt + 1'b1;
    if (clear || (cnt == div)) cnt_n = '0;
  end

  assign period_end = active && (cnt == div);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      out    <= 1'b0;
      active <= 1'b0;
    end else begin
      active <= run;
      cnt    <= run ? cnt_n : '0;
      out    <= run && (cnt_n > (div >> 1));
    end
  end

endmodule

// File: rtl/div_sweep_ctrl.sv
// Programmable frequency-sweep sequencer for the variable clock divider.
// A host fills a table of {div, hold} entries; start walks the first
// num_entries entries, running each for hold output periods. Divide changes
// only happen in LOAD, i.e. on a period boundary, so no runt pulses occur.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   wr_en/idx/div/hold : table write port, ignored while busy
//   num_entries    : active entry count, sampled at start (clamped to DEPTH)
//   start, abort   : begin sweep / stop at once (abort has priority)
//   loop           : only with DIV_SWEEP_LOOP_EN; restart at entry 0 after
//                    the last entry instead of finishing
//   out            : divided waveform
//   cur_div/cur_idx: divide value and entry currently applied
//   busy, done     : high in LOAD/RUN; one-cycle pulse on finish or abort
//   dbg_state      : FSM state, for observation
// Valid/ready: there is no handshake; start and wr_en are single-cycle
// strobes accepted only when busy is low, and done is a one-cycle pulse.
// Optional feature macro: DIV_SWEEP_LOOP_EN.
module div_sweep_ctrl
  import div_sweep_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DIV_W-1:0]        wr_div,
  input  logic [HOLD_W-1:0]       wr_hold,
  input  logic [$clog2(DEPTH):0]  num_entries,
  input  logic                    start,
  input  logic                    abort,
`ifdef DIV_SWEEP_LOOP_EN
  input  logic                    loop,
`endif
  output logic                    out,
  output logic [DIV_W-1:0]        cur_div,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic                    busy,
  output logic                    done,
  output state_t                  dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = IW + 1;

  entry_t           tbl [DEPTH];
  entry_t           ent;
  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [NW-1:0]    n, n_n, n_cl;
  logic [HOLD_W-1:0] rem, rem_n;
  logic [DIV_W-1:0] cur_div_n, core_div;
  logic             ran, ran_n;   // some entry ran in this pass (loop livelock guard)
  logic             loop_go, last, period_end;

`ifdef DIV_SWEEP_LOOP_EN
  assign loop_go = loop;
`else
  assign loop_go = 1'b0;
`endif

  assign ent  = tbl[idx];
  assign last = (({1'b0, idx} + NW'(1)) == n);
  // Counts above DEPTH would never match idx+1, so clamp them.
  assign n_cl = (num_entries > NW'(DEPTH)) ? NW'(DEPTH) : num_entries;
  // The core needs the incoming divide value on the LOAD->RUN edge.
  assign core_div = (state == LOAD) ? ent.div : cur_div;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) tbl[wr_idx] <= '{div: wr_div, hold: HOLD_MAX_W'(wr_hold)};
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    n_n       = n;
    rem_n     = rem;
    ran_n     = ran;
    cur_div_n = cur_div;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          state_n = LOAD;
          idx_n   = '0;
          n_n     = n_cl;
          ran_n   = 1'b0;
        end
      end
      LOAD: begin
        if (abort || (n == '0)) begin
          state_n = DONE;
        end else if (ent.hold != '0) begin
          state_n   = RUN;
          cur_div_n = ent.div;
          rem_n     = HOLD_W'(ent.hold);
          ran_n     = 1'b1;
        end else if (!last) begin
          idx_n = idx + 1'b1;
        end else if (loop_go && ran) begin
          idx_n = '0;
          ran_n = 1'b0;
        end else begin
          state_n = DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = DONE;
        end else if (period_end) begin
          rem_n = rem - 1'b1;
          if (rem == HOLD_W'(1)) begin
            if (!last) begin
              state_n = LOAD;
              idx_n   = idx + 1'b1;
            end else if (loop_go) begin
              state_n = LOAD;
              idx_n   = '0;
              ran_n   = 1'b0;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      default: state_n = IDLE;  // DONE lasts one cycle
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      n       <= '0;
      rem     <= '0;
      ran     <= 1'b0;
      cur_div <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      n       <= n_n;
      rem     <= rem_n;
      ran     <= ran_n;
      cur_div <= cur_div_n;
      busy    <= (state_n == LOAD) || (state_n == RUN);
      done    <= (state_n == DONE);
    end
  end

  assign cur_idx   = idx;
  assign dbg_state = state;

  div_core u_core (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != RUN),
    .run        (state_n == RUN),
    .div        (core_div),
    .out        (out),
    .period_end (period_end)
  );

endmodule

// File: tb/tb_div_sweep_ctrl.sv
module tb_div_sweep_ctrl;
  import div_sweep_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [4:0] wr_div = '0;
  logic [7:0] wr_hold = '0;
  logic [3:0] num_entries = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
`ifdef DIV_SWEEP_LOOP_EN
  logic       loop = 1'b0;
`endif
  logic       out, busy, done;
  logic [4:0] cur_div;
  logic [2:0] cur_idx;
  state_t     dbg_state;

  div_sweep_ctrl #(.DEPTH(8), .HOLD_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_div(wr_div),
    .wr_hold(wr_hold), .num_entries(num_entries), .start(start), .abort(abort),
`ifdef DIV_SWEEP_LOOP_EN
    .loop(loop),
`endif
    .out(out), .cur_div(cur_div), .cur_idx(cur_idx), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  // expected sample = {busy, done, out, cur_idx, cur_div}
  logic [10:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  logic [4:0] m_div = '0;
  logic [2:0] m_idx = '0;

  function automatic logic [10:0] pk(logic b, logic d, logic o, logic [2:0] ci, logic [4:0] cd);
    return {b, d, o, ci, cd};
  endfunction

  task automatic push_load(input logic [2:0] i);
    m_idx = i;
    exp_q.push_back(pk(1'b1, 1'b0, 1'b0, m_idx, m_div));
  endtask

  task automatic push_run(input logic [4:0] d, input int len, input logic [31:0] pat);
    m_div = d;
    for (int i = 0; i < len; i++) exp_q.push_back(pk(1'b1, 1'b0, pat[i], m_idx, m_div));
  endtask

  task automatic push_idle();
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, m_idx, m_div));
  endtask

  task automatic push_done();
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, m_idx, m_div));
    push_idle();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic step_check(input string name);
    logic [10:0] got, exp;
    tick();
    got = pk(busy, done, out, cur_idx, cur_div);
    exp = exp_q.pop_front();
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s #%0d: got busy=%b done=%b out=%b idx=%0d div=%0d, expected busy=%b done=%b out=%b idx=%0d div=%0d",
                  name, total, got[10], got[9], got[8], got[7:5], got[4:0],
                  exp[10], exp[9], exp[8], exp[7:5], exp[4:0]);
  endtask

  task automatic drain(input string name);
    while (exp_q.size() != 0) step_check(name);
  endtask

  task automatic write_entry(input logic [2:0] i, input logic [4:0] d, input logic [7:0] h);
    wr_en = 1'b1; wr_idx = i; wr_div = d; wr_hold = h;
    tick();
  endtask

  task automatic go(input logic [3:0] n);
    num_entries = n;
    start = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [4:0]  div;
    logic [7:0]  hold;
    int          len;
    logic [31:0] pat;   // bit i = out in RUN cycle i
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{div: 5'd3,  hold: 8'd2, len: 8,  pat: 32'h0000_00CC};
    vecs[1] = '{div: 5'd0,  hold: 8'd3, len: 3,  pat: 32'h0000_0000};
    vecs[2] = '{div: 5'd1,  hold: 8'd3, len: 6,  pat: 32'h0000_002A};
    vecs[3] = '{div: 5'd4,  hold: 8'd1, len: 5,  pat: 32'h0000_0018};
    vecs[4] = '{div: 5'd2,  hold: 8'd2, len: 6,  pat: 32'h0000_0024};
    vecs[5] = '{div: 5'd5,  hold: 8'd1, len: 6,  pat: 32'h0000_0038};
    vecs[6] = '{div: 5'd31, hold: 8'd1, len: 32, pat: 32'hFFFF_0000};

    repeat (3) tick();
    reset = 1'b0;

    // reset state
    push_idle();
    drain("reset_state");
    total++;
    if (dbg_state === IDLE) passed++;
    else $display("FAIL reset_dbg_state: got %0d expected %0d", dbg_state, IDLE);

    // single-entry sweeps
    foreach (vecs[k]) begin
      write_entry(3'd0, vecs[k].div, vecs[k].hold);
      go(4'd1);
      push_load(3'd0);
      push_run(vecs[k].div, vecs[k].len, vecs[k].pat);
      push_done();
      drain($sformatf("single_div%0d", vecs[k].div));
    end

    // two entries with an odd ratio first
    write_entry(3'd0, 5'd4, 8'd1);
    write_entry(3'd1, 5'd1, 8'd3);
    go(4'd2);
    push_load(3'd0); push_run(5'd4, 5, 32'h18);
    push_load(3'd1); push_run(5'd1, 6, 32'h2A);
    push_done();
    drain("two_entry");

    // skipped entry costs one LOAD cycle
    write_entry(3'd0, 5'd9, 8'd0);
    write_entry(3'd1, 5'd2, 8'd1);
    go(4'd2);
    push_load(3'd0); push_load(3'd1);
    push_run(5'd2, 3, 32'h4);
    push_done();
    drain("skip");

    // empty sweep
    go(4'd0);
    push_load(3'd0);
    push_done();
    drain("empty");

    // abort mid-period at count 5
    write_entry(3'd0, 5'd7, 8'd5);
    go(4'd1);
    push_load(3'd0); push_run(5'd7, 6, 32'h30);
    drain("abort_run");
    abort = 1'b1;
    push_done();
    drain("abort_done");

    // start together with abort in IDLE
    start = 1'b1; abort = 1'b1;
    push_idle(); push_idle();
    drain("start_abort");

    // table write while busy is dropped; reset mid-RUN
    write_entry(3'd0, 5'd3, 8'd1);
    go(4'd1);
    push_load(3'd0); push_run(5'd3, 2, 32'h0);
    drain("pre_reset");
    wr_en = 1'b1; wr_idx = 3'd0; wr_div = 5'd9; wr_hold = 8'd9;
    exp_q.push_back(pk(1'b1, 1'b0, 1'b1, 3'd0, 5'd3));
    drain("busy_write");
    reset = 1'b1;
    m_div = '0; m_idx = '0;
    push_idle();
    drain("reset_run");
    reset = 1'b0;
    push_idle();
    drain("post_reset");
    go(4'd1);
    push_load(3'd0); push_run(5'd3, 4, 32'hC);
    push_done();
    drain("table_kept");

`ifdef DIV_SWEEP_LOOP_EN
    write_entry(3'd0, 5'd1, 8'd1);
    loop = 1'b1;
    go(4'd1);
    push_load(3'd0);
    for (int r = 0; r < 3; r++) begin
      push_run(5'd1, 2, 32'h2);
      push_load(3'd0);
    end
    drain("loop_run");
    abort = 1'b1;
    push_done();
    drain("loop_abort");
    write_entry(3'd0, 5'd1, 8'd0);
    go(4'd1);
    push_load(3'd0);
    push_done();
    drain("loop_all_skip");
    loop = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
